io_pipe_scheduler: RTL and testbench

//   Round-robin scheduler that shares one fixed-latency registered pipeline among NUM_REQ requesters.
//   The pipeline has PIPE_DEPTH stages: input isolation reg, core regs, output isolation reg.

---
 rtl/io_pipe_if.sv | 30 +++
 rtl/io_pipe_scheduler.sv | 119 +++++++++++
 tb/tb_io_pipe_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pipe_if.sv
// Handshake bundle between the requesters/downstream sink (master) and the
// io_pipe_scheduler (slave).
interface io_pipe_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int PIPE_DEPTH = 4
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      flush;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_ready;
    logic [CNT_W-1:0]          inflight;

    modport master (
        output req_valid, req_data, flush, out_ready,
        input  req_ready, out_valid, out_data, out_id, inflight
    );

    modport slave (
        input  req_valid, req_data, flush, out_ready,
        output req_ready, out_valid, out_data, out_id, inflight
    );
endinterface

// File: rtl/io_pipe_scheduler.sv
// Round-robin scheduler sharing one fixed-latency, ID-tagged register pipeline
// among NUM_REQ requesters; a stalled output holds every stage.
module io_pipe_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int PIPE_DEPTH = 4
) (
    input logic      clk,
    input logic      async_reset,
    io_pipe_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam int LAST  = PIPE_DEPTH - 1;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t            pipe_q [PIPE_DEPTH];
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              advance;
    logic              accept;
    logic              leave;
    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand;
    stage_t            in_stage;
    logic [DATA_W-1:0] req_words [NUM_REQ];
    logic [PIPE_DEPTH-1:0] valid_vec;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_words[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // A valid item nobody takes freezes the whole pipe.
    assign advance = ~(pipe_q[LAST].valid & ~bus.out_ready);
    assign accept  = advance & ~bus.flush & grant_any;
    assign leave   = pipe_q[LAST].valid & bus.out_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept && !async_reset) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        in_stage = '0;
        if (grant_any) begin
            in_stage.valid = 1'b1;
            in_stage.id    = grant_id;
            in_stage.data  = req_words[grant_id];
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            // NOTE: the stage array is reset so nothing stale can surface at the output after reset.
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
            ptr_q   <= ID_W'(NUM_REQ - 1);
            count_q <= '0;
        end else if (bus.flush) begin
            // Payload fields keep stale values; only the valids matter.
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_q[k].valid <= 1'b0;
            end
            count_q <= '0;
        end else if (advance) begin
            // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            pipe_q[0] <= in_stage;
            if (grant_any) begin
                ptr_q <= grant_id;
            end
            count_q <= count_q + CNT_W'(accept) - CNT_W'(leave);
        end
    end

    assign bus.out_valid = pipe_q[LAST].valid;
    assign bus.out_data  = pipe_q[LAST].data;
    assign bus.out_id    = pipe_q[LAST].id;
    assign bus.inflight  = count_q;

    always_comb begin
        valid_vec = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            valid_vec[k] = pipe_q[k].valid;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (async_reset)
        $onehot0(bus.req_ready));

    a_count_matches: assert property (@(posedge clk) disable iff (async_reset)
        count_q == CNT_W'($countones(valid_vec)));
endmodule

// File: tb/tb_io_pipe_scheduler.sv
// Randomized and directed bench for io_pipe_scheduler, checked against an
// item-aging queue model of the scheduler.
module tb_io_pipe_scheduler;
    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int PIPE_DEPTH = 4;

    logic clk = 1'b0;
    logic async_reset;

    always #5 clk = ~clk;

    io_pipe_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_DEPTH(PIPE_DEPTH)) bus ();

    io_pipe_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    // Model: every accepted item ages by one per advancing edge; it is visible
    // at the output once its age equals PIPE_DEPTH.
    typedef struct {
        int id;
        int data;
        int age;
    } item_t;

    item_t q[$];
    int    m_ptr;
    int    m_g;
    bit    m_adv;
    bit    m_flush;
    int    m_gdata;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        for (int off = 1; off <= NUM_REQ; off++) begin
            int i;
            i = (m_ptr + off) % NUM_REQ;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ptr = NUM_REQ - 1;
    endtask

    task automatic sample(input string tag);
        bit exp_ov;
        logic [NUM_REQ-1:0] exp_rr;
        #1;
        m_g     = model_grant();
        exp_ov  = (q.size() > 0) && (q[0].age == PIPE_DEPTH);
        m_adv   = !(exp_ov && !bus.out_ready);
        m_flush = bus.flush;
        exp_rr  = '0;
        if (m_adv && !m_flush && m_g >= 0) begin
            exp_rr  = NUM_REQ'(1) << m_g;
            m_gdata = int'(DATA_W'(bus.req_data >> (m_g * DATA_W)));
        end
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check({tag, "/out_data"}, 32'(bus.out_data), 32'(q[0].data));
            check({tag, "/out_id"}, 32'(bus.out_id), 32'(q[0].id));
        end
        check({tag, "/inflight"}, 32'(bus.inflight), 32'(q.size()));
        check({tag, "/req_ready"}, 32'(bus.req_ready), 32'(exp_rr));
    endtask

    task automatic model_edge();
        if (m_flush) begin
            q.delete();
        end else if (m_adv) begin
            if (q.size() > 0 && q[0].age == PIPE_DEPTH) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (m_g >= 0) begin
                q.push_back('{id: m_g, data: m_gdata, age: 1});
                m_ptr = m_g;
            end
        end
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        async_reset   = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int peak;
        logic [DATA_W-1:0] held_data;
        logic [1:0]        held_id;

        async_reset   = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check("reset/out_valid", 32'(bus.out_valid), 32'd0);
        check("reset/out_data", 32'(bus.out_data), 32'd0);
        check("reset/out_id", 32'(bus.out_id), 32'd0);
        check("reset/inflight", 32'(bus.inflight), 32'd0);
        @(negedge clk);

        // Single requester: latency and occupancy.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00A5;
        #1;
        check("t1/first_grant", 32'(bus.req_ready), 32'h1);
        lat  = -1;
        peak = 0;
        for (int e = 1; e <= 8; e++) begin
            cycle("t1");
            if (bus.out_valid && lat < 0) begin
                lat = e;
                check("t1/data", 32'(bus.out_data), 32'hA5);
                check("t1/id", 32'(bus.out_id), 32'd0);
            end
            if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
        end
        check("t1/latency", 32'(lat), 32'd4);
        check("t1/peak_inflight", 32'(peak), 32'd4);

        // All requesters valid: strict rotation.
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h1312_1110;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("t2/rotation", 32'(bus.req_ready), 32'(1 << (k % NUM_REQ)));
            cycle("t2");
        end

        // Full pipe, downstream stalls for 3 cycles.
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            bus.req_data = $urandom;
            cycle("t3_fill");
        end
        bus.out_ready = 1'b0;
        #1;
        held_data = bus.out_data;
        held_id   = bus.out_id;
        for (int k = 0; k < 3; k++) begin
            bus.req_data = $urandom;
            cycle("t3_stall");
            check("t3/held_data", 32'(bus.out_data), 32'(held_data));
            check("t3/held_id", 32'(bus.out_id), 32'(held_id));
            check("t3/inflight", 32'(bus.inflight), 32'd4);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_data = $urandom;
            cycle("t3_drain");
        end

        // Flush with three items in flight.
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus.req_data = $urandom;
            cycle("t4_fill");
        end
        bus.flush = 1'b1;
        cycle("t4_flush");
        bus.flush = 1'b0;
        #1;
        check("t4/out_valid", 32'(bus.out_valid), 32'd0);
        check("t4/inflight", 32'(bus.inflight), 32'd0);
        check("t4/next_grant", 32'(bus.req_ready), 32'h8);
        cycle("t4_after");

        // Lone requester, then two contenders.
        do_reset();
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            bus.req_data = $urandom;
            #1;
            check("t5/lone_grant", 32'(bus.req_ready), 32'h4);
            cycle("t5_lone");
        end
        bus.req_valid = 4'b1010;
        #1;
        check("t5/grant_3", 32'(bus.req_ready), 32'h8);
        cycle("t5_pair");
        #1;
        check("t5/grant_1", 32'(bus.req_ready), 32'h2);
        cycle("t5_pair");

        // Randomized traffic with stalls and flushes.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.req_valid = NUM_REQ'($urandom);
            bus.req_data  = $urandom;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Asynchronous reset between edges.
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            bus.req_data = $urandom;
            cycle("t6_fill");
        end
        #2;
        async_reset = 1'b1;
        #1;
        check("t6/out_valid", 32'(bus.out_valid), 32'd0);
        check("t6/inflight", 32'(bus.inflight), 32'd0);
        check("t6/req_ready", 32'(bus.req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        #1;
        check("t6/priority", 32'(bus.req_ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            bus.req_data = $urandom;
            cycle("t6_after");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
